rdy_vld_skid_buf: RTL

//  Two-entry skid buffer / register slice for rdy_vld_if links. Accepts beats on a
//  dst-modport port and re-presents them on a src-modport port. Fully registers both
//  the forward path (vld, data) and the backward path (rdy), which breaks long

---
 rtl/rdy_vld_skid_buf_if.sv | 10 +
 rtl/rdy_vld_skid_buf.sv | 58 +++++
 2 files changed

// File: rtl/rdy_vld_skid_buf_if.sv
// rdy_vld_if: ready/valid link carrying one data_st payload per beat
interface rdy_vld_if #(
  parameter type data_st = logic [1:0]
) ();
  data_st data;
  logic   vld;
  logic   rdy;
  modport src(output data, output vld, input rdy);
  modport dst(input data, input vld, output rdy);
endinterface

// File: rtl/rdy_vld_skid_buf.sv
// rdy_vld_skid_buf: two-entry skid buffer that registers both vld/data and rdy
module rdy_vld_skid_buf #(
  parameter type data_st = logic [1:0]
) (
  input  logic        clk,
  input  logic        rst_n,
  rdy_vld_if.dst      in_if,
  rdy_vld_if.src      out_if,
  output logic [1:0]  occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;
  state_t state;
  data_st skid;
  logic   in_xfer;
  logic   out_xfer;
  assign in_xfer   = in_if.vld & in_if.rdy;
  assign out_xfer  = out_if.vld & out_if.rdy;
  assign occupancy = 2'(state);
  // state, main (out_if.data), skid and the registered vld/rdy handshakes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= EMPTY;
      in_if.rdy   <= 1'b0;
      out_if.vld  <= 1'b0;
      out_if.data <= '0;
      skid        <= '0;
    end else case (state)
      EMPTY: begin
        in_if.rdy <= 1'b1;
        if (in_xfer) begin
          state       <= BUSY;
          out_if.vld  <= 1'b1;
          out_if.data <= in_if.data;
        end
      end
      BUSY:
        if (in_xfer && out_xfer) out_if.data <= in_if.data;
        else if (in_xfer) begin
          state     <= FULL;
          skid      <= in_if.data;
          in_if.rdy <= 1'b0;
        end else if (out_xfer) begin
          state      <= EMPTY;
          out_if.vld <= 1'b0;
        end
      FULL:
        if (out_xfer) begin
          state       <= BUSY;
          out_if.data <= skid;
          in_if.rdy   <= 1'b1;
        end
      default: begin
        state      <= EMPTY;
        in_if.rdy  <= 1'b1;
        out_if.vld <= 1'b0;
      end
    endcase
endmodule
